// File: rtl/bcd_disp_pkg.sv
// Shared types, segment constants and BCD-to-7-segment decode for the scanned display.
// Segment patterns are active-low, bit0 = a through bit6 = g.
package bcd_disp_pkg;

    typedef logic [3:0] bcd_t;
    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h7F;
    localparam seg_t SEG_DASH  = 7'b0111111;

    // Codes 10-15 render as a dash so a corrupt value is visible, not silently wrong.
    function automatic seg_t bcd_to_seg(input bcd_t d);
        seg_t s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bcd_scan_timer.sv
// Refresh prescaler and digit scan index; flags the frame boundary (last tick of last digit).
// frame pulses for one cycle as the index returns to 0; free-running, no backpressure.
module bcd_scan_timer #(
    parameter int DIGITS   = 5,
    parameter int TICK_DIV = 50000,
    parameter int CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1,
    parameter int IW       = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic          clk,
    input  logic          reset,
    output logic [CW-1:0] count,
    output logic [IW-1:0] index,
    output logic          boundary,
    output logic          frame
);

    localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);

    logic tick;

    assign tick     = (count == CNT_MAX);
    assign boundary = tick && (index == IDX_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            index <= '0;
            frame <= 1'b0;
        end else begin
            frame <= boundary;
            if (tick) begin
                count <= '0;
                index <= (index == IDX_MAX) ? '0 : index + 1'b1;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/bcd_seg_scan.sv
// Captures BCD digits on valid_i and scans them onto a common-anode 7-segment display,
// swapping content only at frame boundaries; an_o/seg_o lag count/index by 1 cycle; never backpressures.
module bcd_seg_scan
    import bcd_disp_pkg::*;
#(
    parameter int DIGITS    = 5,
    parameter int TICK_DIV  = 50000,
    parameter int BLANK_CYC = 2
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              valid_i,
    input  bcd_t              bcd_digits_i [DIGITS],
    input  logic              blank_lz_i,
    output logic [DIGITS-1:0] an_o,
    output seg_t              seg_o,
    output logic              frame_o
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [CW-1:0]     count;
    logic [IW-1:0]     index;
    logic              boundary;

    bcd_t              pending [DIGITS];
    bcd_t              display [DIGITS];
    logic              pending_flag;
    logic              shown_once;

    logic              past_blank;
    logic              zero_run;
    logic [DIGITS-1:0] blanked;
    logic [DIGITS-1:0] an_next;
    seg_t              seg_next;

    bcd_scan_timer #(
        .DIGITS   (DIGITS),
        .TICK_DIV (TICK_DIV),
        .CW       (CW),
        .IW       (IW)
    ) u_timer (
        .clk      (clk_i),
        .reset    (reset_i),
        .count    (count),
        .index    (index),
        .boundary (boundary),
        .frame    (frame_o)
    );

    // A valid coinciding with the boundary lands in pending after the old pending is applied.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < DIGITS; i++) begin
                pending[i] <= '0;
                display[i] <= '0;
            end
            pending_flag <= 1'b0;
            shown_once   <= 1'b0;
        end else begin
            if (boundary && pending_flag) begin
                display      <= pending;
                pending_flag <= 1'b0;
                shown_once   <= 1'b1;
            end
            if (valid_i) begin
                pending      <= bcd_digits_i;
                pending_flag <= 1'b1;
            end
        end
    end

    generate
        if (BLANK_CYC == 0) begin : g_no_gap
            assign past_blank = 1'b1;
        end else begin : g_gap
            assign past_blank = (count >= CW'(BLANK_CYC));
        end
    endgenerate

    always_comb begin
        zero_run = 1'b1;
        blanked  = '0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            zero_run   = zero_run && (display[i] == 4'd0);
            blanked[i] = blank_lz_i && zero_run;
        end

        an_next  = '1;
        seg_next = SEG_BLANK;
        for (int i = 0; i < DIGITS; i++) begin
            if ((index == IW'(i)) && shown_once && past_blank && !blanked[i]) begin
                an_next[i] = 1'b0;
                seg_next   = bcd_to_seg(display[i]);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            an_o  <= '1;
            seg_o <= SEG_BLANK;
        end else begin
            an_o  <= an_next;
            seg_o <= seg_next;
        end
    end

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Directed bench for bcd_seg_scan at DIGITS=5, TICK_DIV=4, BLANK_CYC=1 (20-cycle frame).
module tb_bcd_seg_scan;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SD = 7'b0111111;
    localparam logic [6:0] SB = 7'h7F;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic       valid_i;
    logic [3:0] bcd_digits_i [5];
    logic       blank_lz_i;
    logic [4:0] an_o;
    logic [6:0] seg_o;
    logic       frame_o;

    int checks = 0;
    int errors = 0;
    int seen;

    always #5 clk_i = ~clk_i;

    bcd_seg_scan #(
        .DIGITS    (5),
        .TICK_DIV  (4),
        .BLANK_CYC (1)
    ) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .valid_i      (valid_i),
        .bcd_digits_i (bcd_digits_i),
        .blank_lz_i   (blank_lz_i),
        .an_o         (an_o),
        .seg_o        (seg_o),
        .frame_o      (frame_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_digits(input logic [19:0] v);
        for (int i = 0; i < 5; i++) bcd_digits_i[i] = v[4*i +: 4];
    endtask

    task automatic wait_frame();
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!frame_o && n < 40);
        check("frame_wait", {31'd0, frame_o}, 32'd1);
    endtask

    // Starts on a frame_o cycle and ends on the next one; optional valid pulses at offsets p1/p2.
    task automatic capture_frame(input logic [4:0] mask, input logic [34:0] segs,
                                 input int p1, input logic [19:0] d1,
                                 input int p2, input logic [19:0] d2);
        int k;
        int ph;
        logic [4:0] ea;
        logic [6:0] es;
        for (int i = 1; i <= 20; i++) begin
            step();
            k  = (i - 1) / 4;
            ph = (i - 1) % 4;
            if (ph != 0 && mask[k]) begin
                ea = ~(5'b00001 << k);
                es = segs[7*k +: 7];
            end else begin
                ea = 5'h1F;
                es = SB;
            end
            check($sformatf("an slot%0d ph%0d", k, ph), {27'd0, an_o}, {27'd0, ea});
            check($sformatf("seg slot%0d ph%0d", k, ph), {25'd0, seg_o}, {25'd0, es});
            check($sformatf("frame off%0d", i), {31'd0, frame_o}, (i == 20) ? 32'd1 : 32'd0);
            valid_i = 1'b0;
            if (i == p1) begin
                set_digits(d1);
                valid_i = 1'b1;
            end
            if (i == p2) begin
                set_digits(d2);
                valid_i = 1'b1;
            end
        end
        valid_i = 1'b0;
    endtask

    initial begin
        reset_i    = 1'b1;
        valid_i    = 1'b0;
        blank_lz_i = 1'b1;
        set_digits(20'h0);
        repeat (3) step();
        check("reset an", {27'd0, an_o}, 32'h1F);
        check("reset seg", {25'd0, seg_o}, 32'h7F);
        check("reset frame", {31'd0, frame_o}, 32'd0);
        reset_i = 1'b0;

        wait_frame();
        // Nothing applied yet: dark frame, load 37.
        capture_frame(5'b00000, {SB, SB, SB, SB, SB}, 1, 20'h00037, -1, 20'h0);
        // 37 with leading zeros suppressed; 65535 arrives mid-frame.
        capture_frame(5'b00011, {SB, SB, SB, S3, S7}, 10, 20'h65535, -1, 20'h0);
        blank_lz_i = 1'b0;
        capture_frame(5'b11111, {S6, S5, S5, S3, S5}, 10, 20'h00000, -1, 20'h0);
        blank_lz_i = 1'b1;
        capture_frame(5'b00001, {SB, SB, SB, SB, S0}, -1, 20'h0, -1, 20'h0);
        blank_lz_i = 1'b0;
        capture_frame(5'b11111, {S0, S0, S0, S0, S0}, 10, 20'h00A01, -1, 20'h0);
        blank_lz_i = 1'b1;
        // Invalid digit; two loads in one frame, only the last survives.
        capture_frame(5'b00111, {SB, SB, SD, S0, S1}, 3, 20'h00012, 12, 20'h00099);
        // 12 pending, then 42 coincident with the boundary.
        capture_frame(5'b00011, {SB, SB, SB, S9, S9}, 5, 20'h00012, 19, 20'h00042);
        capture_frame(5'b00011, {SB, SB, SB, S1, S2}, -1, 20'h0, -1, 20'h0);
        capture_frame(5'b00011, {SB, SB, SB, S4, S2}, -1, 20'h0, -1, 20'h0);

        // Reset while digit 0 is lit.
        step();
        step();
        check("lit before reset an", {27'd0, an_o}, 32'h1E);
        check("lit before reset seg", {25'd0, seg_o}, {25'd0, S2});
        reset_i = 1'b1;
        step();
        check("midscan reset an", {27'd0, an_o}, 32'h1F);
        check("midscan reset seg", {25'd0, seg_o}, 32'h7F);
        check("midscan reset frame", {31'd0, frame_o}, 32'd0);
        step();
        reset_i = 1'b0;
        seen = 0;
        for (int i = 0; i < 45; i++) begin
            step();
            check("post reset an", {27'd0, an_o}, 32'h1F);
            check("post reset seg", {25'd0, seg_o}, 32'h7F);
            if (frame_o) seen++;
        end
        check("post reset frames", seen, 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
